fir_dpath_unr: RTL

- Generalised successor to the unrolled mixer plus FIR datapath.
- Accepts UNR parallel input samples per clock and optionally mixes them with an fs/4 sine sequence.
- Shifts them into a shared history buffer and computes UNR polyphase FIR lane outputs against a runtime-loadable NTAPS coefficient bank.
- Produces registered per-lane outputs plus a saturated lane sum, with valid tracking, stall and flush support.

---
 rtl/fir_dpath_unr.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fir_dpath_unr.sv
// fir_dpath_unr: UNR-lane fs/4 mixer with polyphase FIR, saturated lane outputs and lane sum
module fir_dpath_unr #(
  parameter int DWIDTH = 14,
  parameter int CWIDTH = 11,
  parameter int NTAPS  = 37,
  parameter int UNR    = 4,
  parameter int OWIDTH = 26,
  localparam int CAW = NTAPS > 1 ? $clog2(NTAPS) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [UNR*DWIDTH-1:0]    din,
  input  logic                     din_valid,
  input  logic                     mix_en,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [CAW-1:0]           coef_addr,
  input  logic [CWIDTH-1:0]        coef_data,
  output logic [UNR*OWIDTH-1:0]    dout_lane,
  output logic [OWIDTH-1:0]        dout,
  output logic                     dout_valid,
  output logic                     ovf
);
  localparam int MW   = DWIDTH + 1;
  localparam int ACCW = DWIDTH + 1 + CWIDTH + $clog2(NTAPS);
  localparam int SW   = ACCW + $clog2(UNR);
  localparam int HL   = NTAPS - 1 + UNR;
  localparam int WW   = SW > OWIDTH ? SW : OWIDTH;
  localparam logic signed [WW-1:0] HI = {{(WW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] LO = ~HI;
  logic signed [CWIDTH-1:0] c [NTAPS];
  logic signed [MW-1:0] h [HL];
  logic signed [MW-1:0] hn [HL];
  logic [1:0] phase;
  logic signed [ACCW-1:0] acc [UNR];
  logic signed [ACCW-1:0] acc_r [UNR];
  logic signed [ACCW-1:0] lane_r [UNR];
  logic signed [SW-1:0] tot, sum_r;
  logic v1, v2;
  logic [OWIDTH:0] ls [UNR];
  logic [OWIDTH:0] ds;
  logic [UNR*OWIDTH-1:0] lane_pk;
  logic lane_ovf;
  function automatic logic signed [MW-1:0] mix(input logic signed [DWIDTH-1:0] d, input logic [1:0] n, input logic en);
    logic signed [MW-1:0] x;
    x = MW'(d);
    return !en ? x : !n[0] ? '0 : n[1] ? -x : x;
  endfunction
  function automatic logic [OWIDTH:0] sat(input logic signed [WW-1:0] x);
    return x > HI ? {1'b1, HI[OWIDTH-1:0]} : x < LO ? {1'b1, LO[OWIDTH-1:0]} : {1'b0, x[OWIDTH-1:0]};
  endfunction
  // history as it will look after accepting the current block, lane 0 oldest
  always_comb begin
    for (int j = UNR; j < HL; j++) hn[j] = h[j-UNR];
    for (int i = 0; i < UNR; i++) hn[UNR-1-i] = mix(din[i*DWIDTH +: DWIDTH], phase + 2'(i), mix_en);
  end
  // full-precision lane dot products against the coefficients in force at the accept edge
  always_comb begin
    for (int i = 0; i < UNR; i++) begin
      acc[i] = '0;
      for (int k = 0; k < NTAPS; k++) acc[i] = acc[i] + ACCW'(c[k]) * ACCW'(hn[UNR-1-i+k]);
    end
  end
  // coefficient bank, out-of-range addresses ignored
  always_ff @(posedge CLK)
    if (RST) c <= '{default: '0};
    else if (coef_we && 32'(coef_addr) < NTAPS) c[coef_addr] <= coef_data;
  // accept stage: history, phase and lane products
  always_ff @(posedge CLK)
    if (RST || flush) begin
      h <= '{default: '0};
      acc_r <= '{default: '0};
      phase <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= din_valid;
      if (din_valid) begin
        h <= hn;
        acc_r <= acc;
        phase <= phase + 2'(UNR);
      end
    end
  // full-precision lane sum
  always_comb begin
    tot = '0;
    for (int i = 0; i < UNR; i++) tot = tot + SW'(acc_r[i]);
  end
  // lane result stage
  always_ff @(posedge CLK)
    if (RST || flush) begin
      lane_r <= '{default: '0};
      sum_r <= '0;
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        lane_r <= acc_r;
        sum_r <= tot;
      end
    end
  // saturate lanes and sum to the output width
  always_comb begin
    lane_pk = '0;
    lane_ovf = 1'b0;
    for (int i = 0; i < UNR; i++) begin
      ls[i] = sat(WW'(lane_r[i]));
      lane_pk[i*OWIDTH +: OWIDTH] = ls[i][OWIDTH-1:0];
      lane_ovf = lane_ovf | ls[i][OWIDTH];
    end
    ds = sat(WW'(sum_r));
  end
  // output stage, holds data between results; flush cancels a result about to emerge
  always_ff @(posedge CLK)
    if (RST) begin
      dout_lane <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      dout_valid <= v2 & ~flush;
      ovf <= v2 & ~flush & (lane_ovf | ds[OWIDTH]);
      if (v2 && !flush) begin
        dout_lane <= lane_pk;
        dout <= ds[OWIDTH-1:0];
      end
    end
endmodule
